// File: rtl/shift_sequencer.sv
// Multi-cycle shifter for SLL/SRL/SRA: moves the work register one bit per cycle
// while stall holds the core. The result is presented with a one-cycle done pulse.
module shift_sequencer #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               flush,
    input  logic [1:0]         shift_op,
    input  logic [XLEN-1:0]    operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               stall,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    result,
    output logic               err
);

    typedef enum logic [1:0] {
        st_idle  = 2'b00,
        st_shift = 2'b01,
        st_done  = 2'b10
    } state_t;

    localparam logic [1:0]         OP_SLL  = 2'b00;
    localparam logic [1:0]         OP_SRA  = 2'b11;
    localparam logic [1:0]         OP_RSVD = 2'b10;
    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);
    localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;

    state_t             state_reg, state_next;
    logic [1:0]         op_reg, op_next;
    logic [XLEN-1:0]    work_reg, work_next;
    logic [SHAMT_W-1:0] cnt_reg, cnt_next;
    logic [XLEN-1:0]    result_reg, result_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;

    logic               can_accept;
    logic               shift_left;
    logic               shift_arith;
    logic [XLEN-1:0]    work_shifted;

    assign can_accept  = (state_reg == st_idle) || (state_reg == st_done);
    assign shift_left  = (op_reg == OP_SLL);
    assign shift_arith = (op_reg == OP_SRA);

    // One-bit shift network; the end bits take the fill value (zero or sign).
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign work_shifted[gi] = shift_left ? 1'b0 : work_reg[gi+1];
            end else if (gi == XLEN - 1) begin : g_msb
                assign work_shifted[gi] = shift_left  ? work_reg[gi-1] :
                                          shift_arith ? work_reg[XLEN-1] : 1'b0;
            end else begin : g_mid
                assign work_shifted[gi] = shift_left ? work_reg[gi-1] : work_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        work_next   = work_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        err_next    = 1'b0;

        case (state_reg)
            st_idle, st_done: begin
                if (flush) begin
                    state_next = st_idle;
                end else if (start) begin
                    op_next   = shift_op;
                    work_next = operand;
                    if (shift_op == OP_RSVD) begin
                        // Reserved encoding passes the operand through and flags it.
                        cnt_next    = CNT_ZERO;
                        result_next = operand;
                        err_next    = 1'b1;
                        state_next  = st_done;
                    end else if (shamt == CNT_ZERO) begin
                        cnt_next    = CNT_ZERO;
                        result_next = operand;
                        state_next  = st_done;
                    end else begin
                        cnt_next   = shamt;
                        state_next = st_shift;
                    end
                end else begin
                    state_next = st_idle;
                end
            end
            st_shift: begin
                if (flush) begin
                    cnt_next   = CNT_ZERO;
                    state_next = st_idle;
                end else begin
                    // cnt is at least one here, so the decrement cannot wrap.
                    work_next = work_shifted;
                    cnt_next  = cnt_reg - CNT_ONE;
                    err_next  = start;
                    if (cnt_reg == CNT_ONE) begin
                        result_next = work_shifted;
                        state_next  = st_done;
                    end
                end
            end
            default: begin
                state_next = st_idle;
            end
        endcase
    end

    assign busy_next = (state_next == st_shift);
    assign done_next = (state_next == st_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= st_idle;
            op_reg     <= '0;
            work_reg   <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            work_reg   <= work_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    assign stall  = (start && can_accept && !flush) || (state_reg == st_shift);
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign err    = err_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized checks of shift_sequencer against an arithmetic
// model of the shift result and the start-to-done timing.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [1:0]  shift_op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_result;

    always #5 clk = ~clk;

    shift_sequencer #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .flush    (flush),
        .shift_op (shift_op),
        .operand  (operand),
        .shamt    (shamt),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .err      (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input int sh);
        case (op)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b11:   return 32'($signed(a) >>> sh);
            default: return a;
        endcase
    endfunction

    // Issues start in the current cycle and follows the operation to its done cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input int sh, input string tag);
        int          eff;
        logic [31:0] exp;
        eff = (op == 2'b10) ? 0 : sh;
        exp = model(op, a, eff);
        start = 1'b1; shift_op = op; operand = a; shamt = sh[4:0];
        #1;
        chk({tag, "_stall_start"}, 32'(stall), 32'd1);
        tick;
        start = 1'b0; shift_op = 2'($urandom); operand = $urandom; shamt = 5'($urandom);
        #1;
        for (int k = 1; k <= eff; k++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_done_early"}, 32'(done), 32'd0);
            chk({tag, "_err_shift"}, 32'(err), 32'd0);
            chk({tag, "_stall_shift"}, 32'(stall), 32'd1);
            chk({tag, "_result_held"}, result, last_result);
            tick;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_err_done"}, 32'(err), (op == 2'b10) ? 32'd1 : 32'd0);
        chk({tag, "_stall_done"}, 32'(stall), 32'd0);
        chk({tag, "_result"}, result, exp);
        $display("op %b operand %h shamt %0d -> result %h (expected %h)", op, a, sh, result, exp);
        last_result = exp;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        shift_op = 2'b00; operand = '0; shamt = '0;
        last_result = '0;
        repeat (3) tick;
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        tick;

        // SLL 1 by 4, then back-to-back SLL 3 by 1 in the done cycle
        run_op(2'b00, 32'h0000_0001, 4, "sll4");
        run_op(2'b00, 32'h0000_0003, 1, "b2b");
        tick;

        // Maximum shift amount, arithmetic then logical
        run_op(2'b11, 32'h8000_0000, 31, "sra31");
        run_op(2'b01, 32'h8000_0000, 31, "srl31");
        tick;

        // Zero shift amount
        run_op(2'b01, 32'hDEAD_BEEF, 0, "srl0");
        tick;

        // Flush during SHIFT: no done, result keeps its value
        start = 1'b1; shift_op = 2'b00; operand = 32'h0000_000F; shamt = 5'd10;
        tick;
        start = 1'b0;
        tick;
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        #1;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_result", result, last_result);
        for (int k = 0; k < 12; k++) begin
            tick;
            chk("flush_nodone", 32'(done), 32'd0);
        end
        $display("flush during shift: result %h", result);

        // start and flush together: start dropped
        start = 1'b1; flush = 1'b1; shift_op = 2'b01; operand = 32'h1234_5678; shamt = 5'd3;
        #1;
        chk("sf_stall", 32'(stall), 32'd0);
        tick;
        start = 1'b0; flush = 1'b0;
        #1;
        chk("sf_busy", 32'(busy), 32'd0);
        chk("sf_done", 32'(done), 32'd0);
        tick;
        chk("sf_done2", 32'(done), 32'd0);
        $display("start with flush: busy %b done %b", busy, done);

        // start during SHIFT: err pulse, operation unaffected
        start = 1'b1; shift_op = 2'b00; operand = 32'h0000_0007; shamt = 5'd5;
        tick;
        start = 1'b0;
        #1;
        chk("ign_busy1", 32'(busy), 32'd1);
        tick;
        start = 1'b1; shift_op = 2'b01; operand = 32'hFFFF_0000; shamt = 5'd2;
        tick;
        start = 1'b0;
        #1;
        chk("ign_err", 32'(err), 32'd1);
        chk("ign_busy3", 32'(busy), 32'd1);
        tick;
        chk("ign_err_clear", 32'(err), 32'd0);
        tick;
        chk("ign_busy5", 32'(busy), 32'd1);
        tick;
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_result", result, 32'h0000_00E0);
        chk("ign_err_done", 32'(err), 32'd0);
        $display("start during shift: result %h", result);
        last_result = 32'h0000_00E0;
        tick;

        // Reset in the middle of a shift
        start = 1'b1; shift_op = 2'b00; operand = 32'h0000_0001; shamt = 5'd8;
        tick;
        start = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_result", result, 32'd0);
        $display("reset mid-shift: busy %b done %b result %h", busy, done, result);
        last_result = 32'd0;
        tick;

        // Reserved op
        run_op(2'b10, 32'h1234_5678, 9, "rsvd");
        tick;

        // Randomized operations, with and without idle gaps
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra;
            int          rsh;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rsh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1) tick;
            run_op(rop, ra, rsh, "rand");
        end
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
